// File: rtl/as_sram_pkg.sv
// Shared constants and types for the SRAM port-0 arbiter and its read tracker.
package as_sram_pkg;

   localparam int SRAM_AW = 9;
   localparam int SRAM_DW = 32;
   localparam int SRAM_MW = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_WB   = 2'd2
   } req_owner_e;

   // Image of the macro's port-0 pins; csb and web are active-low.
   typedef struct packed {
      logic               csb;
      logic               web;
      logic [SRAM_AW-1:0] addr;
      logic [SRAM_DW-1:0] din;
      logic [SRAM_MW-1:0] wmask;
   } sram_cmd_t;

   typedef struct packed {
      logic       valid;
      req_owner_e owner;
   } rd_tag_t;

   localparam sram_cmd_t SRAM_CMD_IDLE = '{
      csb:   1'b1,
      web:   1'b1,
      addr:  '0,
      din:   '0,
      wmask: '0
   };

   function automatic logic in_window(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
      return (adr & mask) == base;
   endfunction

endpackage

// File: rtl/sram_rd_tracker.sv
// Two-stage owner pipeline: marks which requester owns the read data that the
// macro presents two cycles after a read was granted.
module sram_rd_tracker
   import as_sram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_valid,
   input  req_owner_e issue_owner,
   output logic       core_rvalid,
   output logic       wb_rd_done
);

   rd_tag_t tag_s1;
   rd_tag_t tag_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_s1 <= '{valid: 1'b0, owner: OWN_NONE};
         tag_s2 <= '{valid: 1'b0, owner: OWN_NONE};
      end else begin
         tag_s1.valid <= issue_valid;
         tag_s1.owner <= issue_valid ? issue_owner : OWN_NONE;
         tag_s2       <= tag_s1;
      end
   end

   // Stage 2 lines up with the cycle in which ram_dout carries the data.
   assign core_rvalid = tag_s2.valid & (tag_s2.owner == OWN_CORE);
   assign wb_rd_done  = tag_s2.valid & (tag_s2.owner == OWN_WB);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the macro's read/write port 0 between the TMS1x00 core (priority) and
// the Wishbone slave, with a starvation bound that guarantees Wishbone a slot.
module sram_port_arbiter
   import as_sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK   = 32'hFFFF_F800,
   parameter int          MAX_WB_WAIT = 4,
   parameter int          AW          = SRAM_AW,
   parameter int          DW          = SRAM_DW
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   input  logic [3:0]    core_wmask,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   output logic          ram_csb,
   output logic          ram_web,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic [3:0]    ram_wmask,
   input  logic [DW-1:0] ram_dout
);

   // Handshakes: the core presents core_req with its command and is taken in
   // any cycle where core_gnt is high (combinational, back-to-back allowed).
   // Wishbone holds cyc & stb with a stable command until a one-cycle ack.
   localparam int SW = $clog2(MAX_WB_WAIT + 1);

   logic          wb_hit;
   logic          wb_pend;
   logic          wb_gnt;
   logic          starved;
   logic          wb_busy;
   logic [SW-1:0] starve_cnt;
   logic          wb_wr_q;
   logic          ack_sched;
   logic          wb_rd_done;
   logic          rd_issue;
   req_owner_e    rd_owner;
   sram_cmd_t     cmd_next;
   sram_cmd_t     cmd_q;

   assign wb_hit   = in_window(wbs_adr_i, BASE_ADDR, ADDR_MASK);
   assign wb_pend  = wbs_cyc_i & wbs_stb_i & wb_hit & ~wb_busy;
   assign starved  = (starve_cnt == SW'(MAX_WB_WAIT));
   assign wb_gnt   = wb_pend & (~core_req | starved);
   assign core_gnt = core_req & ~wb_gnt;

   // Address/data hold their last value on idle cycles to avoid needless toggling.
   always_comb begin
      cmd_next     = cmd_q;
      cmd_next.csb = 1'b1;
      cmd_next.web = 1'b1;
      if (wb_gnt) begin
         cmd_next.csb   = 1'b0;
         cmd_next.web   = ~wbs_we_i;
         cmd_next.addr  = wbs_adr_i[AW+1:2];
         cmd_next.din   = wbs_dat_i;
         cmd_next.wmask = wbs_we_i ? wbs_sel_i : 4'h0;
      end else if (core_req) begin
         cmd_next.csb   = 1'b0;
         cmd_next.web   = ~core_we;
         cmd_next.addr  = core_addr;
         cmd_next.din   = core_wdata;
         cmd_next.wmask = core_we ? core_wmask : 4'h0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cmd_q <= SRAM_CMD_IDLE;
      end else begin
         cmd_q <= cmd_next;
      end
   end

   assign ram_csb   = cmd_q.csb;
   assign ram_web   = cmd_q.web;
   assign ram_addr  = cmd_q.addr;
   assign ram_din   = cmd_q.din;
   assign ram_wmask = cmd_q.wmask;

   assign rd_issue = (wb_gnt & ~wbs_we_i) | (core_gnt & ~core_we);
   assign rd_owner = wb_gnt ? OWN_WB : OWN_CORE;

   sram_rd_tracker u_rd_tracker (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .issue_valid (rd_issue),
      .issue_owner (rd_owner),
      .core_rvalid (core_rvalid),
      .wb_rd_done  (wb_rd_done)
   );

   assign core_rdata = ram_dout;

   // A write acks one cycle after it reaches the macro; a read acks once its
   // data has been captured into wbs_dat_o.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_wr_q   <= 1'b0;
         ack_sched <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wb_wr_q   <= wb_gnt & wbs_we_i;
         ack_sched <= wb_wr_q | wb_rd_done;
         if (wb_rd_done) begin
            wbs_dat_o <= ram_dout;
         end
      end
   end

   // An abandoned cycle still completes in the macro but must not be acked.
   assign wbs_ack_o = ack_sched & wbs_cyc_i;

   // Busy spans grant to ack so a strobe held through the ack is not re-granted.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb_busy    <= 1'b0;
         starve_cnt <= '0;
      end else begin
         if (wb_gnt) begin
            wb_busy <= 1'b1;
         end else if (ack_sched) begin
            wb_busy <= 1'b0;
         end
         if (!wb_pend || wb_gnt) begin
            starve_cnt <= '0;
         end else if (!starved) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: macro model, cycle-scheduled behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbs_cyc, wbs_stb, wbs_we;
   logic [3:0]  wbs_sel;
   logic [31:0] wbs_adr, wbs_dat_w;
   logic        wbs_ack;
   logic [31:0] wbs_dat_r;
   logic        core_req, core_we;
   logic [8:0]  core_addr;
   logic [31:0] core_wdata;
   logic [3:0]  core_wmask;
   logic        core_gnt, core_rvalid;
   logic [31:0] core_rdata;
   logic        ram_csb, ram_web;
   logic [8:0]  ram_addr;
   logic [31:0] ram_din;
   logic [3:0]  ram_wmask;
   logic [31:0] ram_dout = '0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_n = 0;

   sram_port_arbiter dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wbs_cyc_i   (wbs_cyc),
      .wbs_stb_i   (wbs_stb),
      .wbs_we_i    (wbs_we),
      .wbs_sel_i   (wbs_sel),
      .wbs_adr_i   (wbs_adr),
      .wbs_dat_i   (wbs_dat_w),
      .wbs_ack_o   (wbs_ack),
      .wbs_dat_o   (wbs_dat_r),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_wmask  (core_wmask),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .ram_csb     (ram_csb),
      .ram_web     (ram_web),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_wmask   (ram_wmask),
      .ram_dout    (ram_dout)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
      end
   endtask

   // ---------------- macro model (data appears the cycle after its access) ----------------
   logic [31:0] mem_hw [512] = '{default: '0};
   always @(posedge clk) begin
      if (!ram_csb) begin
         if (!ram_web) mem_hw[ram_addr] <= apply_mask(mem_hw[ram_addr], ram_din, ram_wmask);
         else          ram_dout <= mem_hw[ram_addr];
      end
   end

   // ---------------- behavioural model / scoreboard ----------------
   typedef struct {
      bit          web;
      logic [8:0]  addr;
      logic [3:0]  wmask;
      logic [31:0] din;
   } cmd_exp_t;

   cmd_exp_t    e_cmd [int];
   bit          e_rv  [int];
   bit          e_ack [int];
   logic [31:0] e_dat [int];
   logic [31:0] exp_q [$];
   logic [31:0] m_mem [512] = '{default: '0};
   int          m_lost = 0;
   int          m_busy_last = -1;

   always @(negedge clk) begin : model_p
      int          n;
      bit          in_win, pend, wgnt, cgnt, exp_ack;
      logic [8:0]  w;
      logic [31:0] rexp;
      n = cyc_n;
      if (rst) begin
         e_cmd.delete(); e_rv.delete(); e_ack.delete(); e_dat.delete(); exp_q.delete();
         m_lost = 0;
         m_busy_last = -1;
         check("rst_csb", ram_csb, 1);
         check("rst_web", ram_web, 1);
         check("rst_addr", ram_addr, 0);
         check("rst_wmask", ram_wmask, 0);
         check("rst_ack", wbs_ack, 0);
         check("rst_dat", wbs_dat_r, 0);
         check("rst_rvalid", core_rvalid, 0);
      end else begin
         if (e_cmd.exists(n)) begin
            check("ram_csb", ram_csb, 0);
            check("ram_web", ram_web, e_cmd[n].web);
            check("ram_addr", ram_addr, e_cmd[n].addr);
            check("ram_wmask", ram_wmask, e_cmd[n].wmask);
            if (!e_cmd[n].web) check("ram_din", ram_din, e_cmd[n].din);
            e_cmd.delete(n);
         end else begin
            check("ram_csb_idle", ram_csb, 1);
            check("ram_web_idle", ram_web, 1);
         end
         check("core_rvalid", core_rvalid, e_rv.exists(n));
         if (e_rv.exists(n)) begin
            rexp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            if (core_rvalid) check("core_rdata", core_rdata, rexp);
            e_rv.delete(n);
         end
         exp_ack = e_ack.exists(n) && wbs_cyc;
         check("wbs_ack", wbs_ack, exp_ack);
         if (exp_ack && e_dat.exists(n)) check("wbs_dat", wbs_dat_r, e_dat[n]);
         e_ack.delete(n);
         e_dat.delete(n);

         // Arbitration for cycle n from the rules: core first, WB after MAX_WB_WAIT losses.
         in_win = (wbs_adr & 32'hFFFF_F800) == 32'h3000_0000;
         pend   = wbs_cyc && wbs_stb && in_win && (n > m_busy_last);
         wgnt   = pend && (!core_req || m_lost == 4);
         cgnt   = core_req && !wgnt;
         check("core_gnt", core_gnt, cgnt);
         m_lost = (pend && !wgnt) ? ((m_lost < 4) ? m_lost + 1 : 4) : 0;
         if (wgnt) begin
            w = wbs_adr[10:2];
            e_cmd[n+1] = '{web: !wbs_we, addr: w, wmask: wbs_we ? wbs_sel : 4'h0, din: wbs_dat_w};
            if (wbs_we) begin
               m_mem[w] = apply_mask(m_mem[w], wbs_dat_w, wbs_sel);
               e_ack[n+2] = 1'b1;
               m_busy_last = n + 2;
            end else begin
               e_ack[n+3] = 1'b1;
               e_dat[n+3] = m_mem[w];
               m_busy_last = n + 3;
            end
         end else if (cgnt) begin
            e_cmd[n+1] = '{web: !core_we, addr: core_addr, wmask: core_we ? core_wmask : 4'h0,
                           din: core_wdata};
            if (core_we) m_mem[core_addr] = apply_mask(m_mem[core_addr], core_wdata, core_wmask);
            else begin
               e_rv[n+2] = 1'b1;
               exp_q.push_back(m_mem[core_addr]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_set(input logic c, input logic s, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
      wbs_cyc = c; wbs_stb = s; wbs_we = we; wbs_adr = adr; wbs_dat_w = dat; wbs_sel = sel;
   endtask

   task automatic core_set(input logic req, input logic we, input logic [8:0] addr,
                           input logic [31:0] d, input logic [3:0] m);
      core_req = req; core_we = we; core_addr = addr; core_wdata = d; core_wmask = m;
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
      bit got;
      got = 1'b0;
      wb_set(1, 1, we, adr, dat, sel);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (wbs_ack) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (got) tick();
      wb_set(0, 0, 0, 0, 0, 0);
      check("wb_ack_within_bound", got, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main_p
      int a, acks, rvs, csb_lo;
      bit ack_seen;
      rst = 1'b1;
      wb_set(0, 0, 0, 0, 0, 0);
      core_set(0, 0, 0, 0, 0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset asserted between clock edges while reads are in flight.
      core_set(1, 0, 9'd0, 0, 0); tick();
      core_set(1, 0, 9'd1, 0, 0); tick();
      core_set(1, 0, 9'd2, 0, 0);
      @(negedge clk);
      check("pre_rst_rvalid", core_rvalid, 1);
      check("pre_rst_csb", ram_csb, 0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_csb", ram_csb, 1);
      check("async_rst_web", ram_web, 1);
      check("async_rst_ack", wbs_ack, 0);
      check("async_rst_rvalid", core_rvalid, 0);
      core_set(0, 0, 0, 0, 0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();

      // WB write with the core idle.
      wb_set(1, 1, 1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
      @(negedge clk); tick();
      @(negedge clk);
      check("wr_csb", ram_csb, 0);
      check("wr_web", ram_web, 0);
      check("wr_addr", ram_addr, 9'd4);
      check("wr_wmask", ram_wmask, 4'hF);
      check("wr_no_early_ack", wbs_ack, 0);
      tick();
      @(negedge clk);
      check("wr_ack", wbs_ack, 1);
      tick();
      wb_set(0, 0, 0, 0, 0, 0);
      tick(); tick();

      // WB read-back; strobe held through the ack cycle.
      wb_set(1, 1, 0, 32'h3000_0010, 0, 4'hF);
      acks = 0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (j == 1) begin
            check("rd_csb", ram_csb, 0);
            check("rd_web", ram_web, 1);
         end
         if (j == 3) begin
            check("rd_ack", wbs_ack, 1);
            check("rd_dat", wbs_dat_r, 32'hDEAD_BEEF);
         end
         if (j == 4) check("rd_no_regrant", ram_csb, 1);
         if (wbs_ack) acks++;
         tick();
         if (j == 3) wb_set(0, 0, 0, 0, 0, 0);
      end
      check("rd_single_ack", acks, 1);

      wb_xfer(1, 32'h3000_0020, 32'hCAFE_0008, 4'hF);
      tick();

      // Starvation bound: core streams reads 0..15, WB read of word 8 raised at j=3.
      a = 0;
      ack_seen = 1'b0;
      for (int j = 0; j < 20; j++) begin
         core_set(a < 16, 0, 9'(a), 0, 0);
         if (j == 3) wb_set(1, 1, 0, 32'h3000_0020, 0, 4'hF);
         @(negedge clk);
         if (j >= 3 && j < 7) check("starve_core_wins", core_gnt, 1);
         if (j == 7) check("starve_wb_slot", core_gnt, 0);
         if (j == 8) begin
            check("starve_core_regrant", core_gnt, 1);
            check("starve_wb_csb", ram_csb, 0);
            check("starve_wb_web", ram_web, 1);
            check("starve_wb_addr", ram_addr, 9'd8);
         end
         if (j == 10) begin
            check("starve_ack", wbs_ack, 1);
            check("starve_dat", wbs_dat_r, 32'hCAFE_0008);
         end
         if (core_gnt) a++;
         if (wbs_ack) ack_seen = 1'b1;
         tick();
         if (ack_seen) wb_set(0, 0, 0, 0, 0, 0);
      end
      core_set(0, 0, 0, 0, 0);
      check("starve_reads_done", a, 16);
      tick(); tick();

      // Out-of-window strobe is never served.
      wb_set(1, 1, 0, 32'h3000_0800, 0, 4'hF);
      acks = 0; csb_lo = 0;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         if (wbs_ack) acks++;
         if (!ram_csb) csb_lo++;
         tick();
      end
      wb_set(0, 0, 0, 0, 0, 0);
      check("oow_no_ack", acks, 0);
      check("oow_no_access", csb_lo, 0);
      tick(); tick();

      // Collision: core write to word 7 and WB read of word 7 in the same cycle.
      for (int j = 0; j < 6; j++) begin
         if (j == 0) begin
            core_set(1, 1, 9'd7, 32'h1234_5678, 4'h3);
            wb_set(1, 1, 0, 32'h3000_001C, 0, 4'hF);
         end
         if (j == 1) core_set(0, 0, 0, 0, 0);
         if (j == 5) wb_set(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (j == 0) check("col_core_first", core_gnt, 1);
         if (j == 1) begin
            check("col_core_csb", ram_csb, 0);
            check("col_core_web", ram_web, 0);
            check("col_core_addr", ram_addr, 9'd7);
            check("col_core_wmask", ram_wmask, 4'h3);
            check("col_core_din", ram_din, 32'h1234_5678);
         end
         if (j == 2) begin
            check("col_wb_csb", ram_csb, 0);
            check("col_wb_web", ram_web, 1);
         end
         if (j == 4) begin
            check("col_wb_ack", wbs_ack, 1);
            check("col_wb_dat", wbs_dat_r, 32'h0000_5678);
         end
         tick();
      end
      tick();

      // Same collision with cyc dropped two cycles in: access completes, no ack.
      acks = 0;
      for (int j = 0; j < 10; j++) begin
         if (j == 0) begin
            core_set(1, 1, 9'd7, 32'hAABB_CCDD, 4'hC);
            wb_set(1, 1, 0, 32'h3000_001C, 0, 4'hF);
         end
         if (j == 1) core_set(0, 0, 0, 0, 0);
         if (j == 2) wb_set(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (j == 2) check("abort_access_issued", ram_csb, 0);
         if (wbs_ack) acks++;
         tick();
      end
      check("abort_no_ack", acks, 0);

      // Reset two cycles after a WB read grant discards it.
      acks = 0; rvs = 0;
      for (int j = 0; j < 16; j++) begin
         if (j == 0) wb_set(1, 1, 0, 32'h3000_001C, 0, 4'hF);
         if (j == 2) begin
            rst = 1'b1;
            wb_set(0, 0, 0, 0, 0, 0);
         end
         if (j == 4) rst = 1'b0;
         @(negedge clk);
         if (j == 1) check("rstrd_granted", ram_csb, 0);
         if (j >= 4 && wbs_ack) acks++;
         if (j >= 4 && core_rvalid) rvs++;
         tick();
      end
      check("rstrd_no_ack", acks, 0);
      check("rstrd_no_rvalid", rvs, 0);

      // Randomized traffic from both requesters.
      fork
         begin : core_drv
            for (int c = 0; c < 1500; c++) begin
               core_set($urandom_range(0, 9) < 6, $urandom_range(0, 1),
                        9'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
               tick();
            end
            core_set(0, 0, 0, 0, 0);
         end
         begin : wb_drv
            logic [31:0] adr;
            for (int k = 0; k < 100; k++) begin
               repeat ($urandom_range(0, 4)) tick();
               if ($urandom_range(0, 9) == 0) begin
                  adr = ($urandom_range(0, 1) == 1) ? 32'h3000_0800 : 32'h2000_0000;
                  adr = adr + 32'($urandom_range(0, 255) * 4);
                  wb_set(1, 1, $urandom_range(0, 1), adr, $urandom, 4'hF);
                  repeat (3) tick();
                  wb_set(0, 0, 0, 0, 0, 0);
               end else begin
                  adr = 32'h3000_0000 + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
                  wb_xfer($urandom_range(0, 1), adr, $urandom, 4'($urandom_range(0, 15)));
               end
            end
         end
      join
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
